// File: rtl/armleocpu_fetch_linebuf.sv
// Single-line instruction buffer answering the fetch cache interface.
// Hits return in one cycle; a miss refills the whole line over a burst-read port.
module armleocpu_fetch_linebuf #(
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  c_cmd,
  input  logic [31:0] c_address,
  output logic        c_done,
  output logic [3:0]  c_response,
  output logic [31:0] c_load_data,
  output logic        m_req_valid,
  input  logic        m_req_ready,
  output logic [31:0] m_req_addr,
  input  logic        m_rsp_valid,
  input  logic [31:0] m_rsp_data,
  input  logic        m_rsp_error
);
  localparam int WB  = $clog2(LINE_WORDS);
  localparam int OFF = WB + 2;
  localparam int TW  = 32 - OFF;
  localparam logic [WB-1:0] LAST_BEAT = WB'(LINE_WORDS - 1);

  localparam logic [3:0] CMD_NONE      = 4'd0;
  localparam logic [3:0] CMD_EXECUTE   = 4'd1;
  localparam logic [3:0] CMD_FLUSH_ALL = 4'd4;

  localparam logic [3:0] RSP_SUCCESS     = 4'd0;
  localparam logic [3:0] RSP_ACCESSFAULT = 4'd1;
  localparam logic [3:0] RSP_MISSALIGNED = 4'd3;
  localparam logic [3:0] RSP_UNKNOWNTYPE = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_REFILL_REQ, S_REFILL_DATA, S_RESPOND
  } state_t;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] addr;
  } req_t;

  state_t                       state_q, state_d;
  req_t                         req_q;
  logic                         valid_q, valid_d;
  logic [TW-1:0]                tag_q, tag_d;
  logic [WB-1:0]                beat_q, beat_d;
  logic                         fault_q, fault_d;
  logic [LINE_WORDS-1:0][31:0]  line_q;
  logic                         line_we;
  logic                         capture;

  logic [TW-1:0] req_tag;
  logic [WB-1:0] req_word;
  assign req_tag  = req_q.addr[31:OFF];
  assign req_word = req_q.addr[OFF-1:2];

  assign m_req_valid = (state_q == S_REFILL_REQ);
  assign m_req_addr  = {req_tag, {OFF{1'b0}}};

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    beat_d      = beat_q;
    fault_d     = fault_q;
    line_we     = 1'b0;
    c_done      = 1'b0;
    c_response  = RSP_SUCCESS;
    c_load_data = '0;

    case (state_q)
      S_LOOKUP: begin
        if (req_q.cmd == CMD_EXECUTE) begin
          if (req_q.addr[1:0] != 2'b00) begin
            c_done     = 1'b1;
            c_response = RSP_MISSALIGNED;
          end else if (valid_q && tag_q == req_tag) begin
            c_done      = 1'b1;
            c_load_data = line_q[req_word];
          end else begin
            // Invalidate first so a partially written line can never hit.
            valid_d = 1'b0;
            state_d = S_REFILL_REQ;
          end
        end else if (req_q.cmd == CMD_FLUSH_ALL) begin
          valid_d = 1'b0;
          c_done  = 1'b1;
        end else begin
          c_done     = 1'b1;
          c_response = RSP_UNKNOWNTYPE;
        end
      end
      S_REFILL_REQ: begin
        if (m_req_ready) state_d = S_REFILL_DATA;
      end
      S_REFILL_DATA: begin
        if (m_rsp_valid) begin
          line_we = 1'b1;
          beat_d  = beat_q + WB'(1);
          if (m_rsp_error) fault_d = 1'b1;
          if (beat_q == LAST_BEAT) state_d = S_RESPOND;
        end
      end
      S_RESPOND: begin
        c_done  = 1'b1;
        fault_d = 1'b0;
        if (fault_q) begin
          c_response = RSP_ACCESSFAULT;
        end else begin
          valid_d     = 1'b1;
          tag_d       = req_tag;
          c_load_data = line_q[req_word];
        end
      end
      default: ;
    endcase

    // A new command is taken when idle or in the same cycle the previous one completes.
    capture = (c_cmd != CMD_NONE) && ((state_q == S_IDLE) || c_done);
    if (c_done)                    state_d = capture ? S_LOOKUP : S_IDLE;
    else if (state_q == S_IDLE && capture) state_d = S_LOOKUP;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      valid_q <= 1'b0;
      tag_q   <= '0;
      beat_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      beat_q  <= beat_d;
      fault_q <= fault_d;
      if (capture) begin
        req_q.cmd  <= c_cmd;
        req_q.addr <= c_address;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && line_we) line_q[beat_q] <= m_rsp_data;
  end
endmodule

// File: doc/armleocpu_fetch_linebuf.md
# armleocpu_fetch_linebuf

Single-line instruction buffer that acts as the responder on the fetch unit's cache interface (`c_cmd`/`c_address` in, `c_done`/`c_response`/`c_load_data` out). It sits between the fetch unit and a simple burst-read backing memory port. It is used as a small-footprint stand-in for the full I-cache. It serves `CACHE_CMD_EXECUTE` hits at one response per cycle, refills one line on a miss, and services `CACHE_CMD_FLUSH_ALL` by invalidating the line.

## Interface
- `LINE_WORDS`, 4: words per line; power of 2, range 2..16.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `c_cmd` in 4: cache command from fetch (`CACHE_CMD_NONE`/`EXECUTE`/`FLUSH_ALL`; any other value is unknown).
- `c_address` in 32: byte address of the request.
- `c_done` out 1: one-cycle completion pulse for the captured request.
- `c_response` out 4: `CACHE_RESPONSE_SUCCESS`/`ACCESSFAULT`/`MISSALIGNED`/`UNKNOWNTYPE`; valid while `c_done`=1.
- `c_load_data` out 32: instruction word; valid while `c_done`=1 and response is SUCCESS for EXECUTE.
- `m_req_valid` out 1: line refill request.
- `m_req_ready` in 1: backing port accepts the request.
- `m_req_addr` out 32: line-aligned refill address (low log2(LINE_WORDS)+2 bits zero).
- `m_rsp_valid` in 1: refill data beat; beats arrive in order, word 0 first.
- `m_rsp_data` in 32: beat data.
- `m_rsp_error` in 1: beat carries a bus error.

## Operation
- Request capture:
  - A request is presented in cycle T when `c_cmd`≠NONE and, in cycle T-1, either `c_cmd`=NONE or `c_done`=1.
  - The block registers `c_cmd`/`c_address` at the end of T and sets `pending`.
  - The initiator holds cmd/address stable until `c_done`.
  - In the cycle `c_done`=1, a new command on `c_cmd` is captured in that same cycle, which gives back-to-back operation.
- State machine: IDLE, LOOKUP, REFILL_REQ, REFILL_DATA, RESPOND.
  - IDLE→LOOKUP on capture.
  - LOOKUP resolves in one cycle:
    - EXECUTE, addr[1:0]≠0: `c_done`, MISSALIGNED, no refill.
    - EXECUTE, line valid and tag (addr[31:log2(LINE_WORDS)+2]) matches: `c_done`, SUCCESS, word addr[log2(LINE_WORDS)+1:2].
    - EXECUTE, miss: go to REFILL_REQ. Set line valid=0 before the first beat is written.
    - FLUSH_ALL: valid=0, `c_done`, SUCCESS.
    - Unknown cmd: `c_done`, UNKNOWNTYPE, line untouched.
    - After a LOOKUP-done: go to LOOKUP if a new request is captured that cycle, else IDLE.
  - REFILL_REQ: `m_req_valid`=1 and `m_req_addr` held stable until `m_req_ready`, then REFILL_DATA.
  - REFILL_DATA:
    - Each `m_rsp_valid` writes the buffer word at the beat counter and increments the counter (log2(LINE_WORDS) bits, wraps to 0 after the last beat).
    - Any `m_rsp_error` sets a sticky fault flag.
    - After beat LINE_WORDS-1, go to RESPOND.
  - RESPOND:
    - Fault=0: line valid=1, tag stored, `c_done`, SUCCESS, requested word.
    - Fault=1: line stays invalid, `c_done`, ACCESSFAULT, `c_load_data`=0.
    - Fault is cleared. Next state follows the same rule as LOOKUP-done.
- `m_rsp_valid` outside REFILL_DATA is ignored.
- `c_cmd`=NONE while `pending`=0 means idle; no output changes.

## Timing
- Reset values: `c_done`=0, `c_response`=SUCCESS, `c_load_data`=0, `m_req_valid`=0, `m_req_addr`=0, line valid=0, state IDLE, beat counter 0, fault 0.
- `rst_n` low mid-refill aborts immediately. The line is left invalid, and beats of the aborted burst are ignored because the state is IDLE.
- `c_done`, `c_response` and `c_load_data` are derived from registered state only. There is no combinational path from `c_cmd`/`c_address`.
- `c_done` is never 1 in the cycle after `c_cmd` was NONE.
- Hit latency is 1 cycle: present at T, `c_done` at T+1. Sustained hits give one `c_done` per cycle.
- Miss timing: present at T, LOOKUP at T+1, `m_req_valid` from T+2. With `m_req_ready`=1 at T+2 and one beat per cycle from T+3, the last beat is at T+2+LINE_WORDS and `c_done` follows at T+3+LINE_WORDS.
- Simultaneous events:
  - FLUSH_ALL captured while a hit is completing is serviced next cycle; the completing hit returns the pre-flush data.
  - A request to the line just refilled, captured in the RESPOND cycle, hits.

## Test plan
- Reset, then EXECUTE at 0x1000 with memory word i = 0xA000_0000+i, `m_req_ready`=1, one beat per cycle → `m_req_addr`=0x1000, `c_done` at T+7, SUCCESS, data 0xA000_0000.
- After that, back-to-back EXECUTE 0x1004, 0x1008, 0x100C → `c_done` on 3 consecutive cycles with 0xA000_0001..3, no `m_req_valid`.
- EXECUTE 0x1002 → `c_done` one cycle later with MISSALIGNED, no refill.
- FLUSH_ALL, then EXECUTE 0x1004 → FLUSH `c_done`/SUCCESS; the EXECUTE then refills again at 0x1000.
- EXECUTE 0x2000 with `m_rsp_error` on beat 2 → ACCESSFAULT with data 0; a repeat of 0x2000 refills again.
- Reset asserted after beat 1 of a refill, then EXECUTE 0x1000 → the stale remaining beats are ignored and the refill restarts with `m_req_valid`, returning correct data.
